// File: rtl/ctrl_pipe.sv
// ---------------------------------------------------------------------------
// ctrl_pipe
// RV32I control decoder and control pipeline for the in-order core. The
// instruction in ID is decoded into a 9-bit control word. That word travels
// with a valid bit and a destination register through CTRL_DEPTH registered
// stages (0=EX, 1=MEM, 2=WB). The block inserts load-use bubbles, handles
// branch/jump flushes and the global stall, and counts the bubbles it
// inserted.
//
// Parameters
//   CTRL_DEPTH   number of registered control stages (>=2)
//   CNT_W        width of the saturating bubble counter
//   LOAD_USE_EN  1: detect load-use hazards and bubble, 0: never bubble
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   id_valid     id_instr holds a valid instruction
//   id_instr     instruction currently in ID
//   id_ready     ID instruction accepted this cycle (combinational)
//   stall_i      freeze the whole control pipe
//   flush_i      branch/jump taken, resolved in stage 0
//   stage_valid  per-stage valid, bit s = stage s
//   stage_ctrl   per-stage control word, stage s at [9s+8:9s]
//   stage_rd     per-stage destination register, stage s at [5s+4:5s]
//   bubble_cnt   number of load-use bubbles inserted, saturating
//
// Control word bit order:
//   {illegal, jump, branch, memread, memtoreg, memwrite[1:0], alusrc, regwrite}
// ---------------------------------------------------------------------------
module ctrl_pipe #(
  parameter int CTRL_DEPTH  = 3,
  parameter int CNT_W       = 16,
  parameter bit LOAD_USE_EN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [31:0]             id_instr,
  output logic                    id_ready,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output logic [CTRL_DEPTH-1:0]   stage_valid,
  output logic [CTRL_DEPTH*9-1:0] stage_ctrl,
  output logic [CTRL_DEPTH*5-1:0] stage_rd,
  output logic [CNT_W-1:0]        bubble_cnt
);

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011
  } opcode_t;

  logic [CTRL_DEPTH-1:0] valid_q;
  logic [8:0]            ctrl_q [CTRL_DEPTH];
  logic [4:0]            rd_q   [CTRL_DEPTH];
  logic [CNT_W-1:0]      cnt_q;

  opcode_t    opcode;
  logic [2:0] funct3;
  logic [8:0] dec_ctrl;
  logic [4:0] dec_rd;
  logic       dec_uses_rs1;
  logic       dec_uses_rs2;
  logic       hazard;

  assign opcode = opcode_t'(id_instr[6:0]);
  assign funct3 = id_instr[14:12];

  // Decode the ID instruction into its control word and note which source
  // registers it reads. Anything we do not recognise becomes an illegal-only
  // word and reads no registers, so it can never cause a load-use bubble.
  // A store with an unsupported width keeps alusrc but is flagged illegal and
  // writes nothing to memory.
  always_comb begin
    dec_ctrl     = 9'h100;
    dec_uses_rs1 = 1'b0;
    dec_uses_rs2 = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        dec_ctrl = 9'h003;
      end
      OPC_OP_IMM: begin
        dec_ctrl     = 9'h003;
        dec_uses_rs1 = 1'b1;
      end
      OPC_OP: begin
        dec_ctrl     = 9'h001;
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OPC_JAL: begin
        dec_ctrl = 9'h083;
      end
      OPC_JALR: begin
        dec_ctrl     = 9'h083;
        dec_uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        dec_ctrl     = 9'h040;
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        dec_ctrl     = 9'h033;
        dec_uses_rs1 = 1'b1;
      end
      OPC_STORE: begin
        dec_uses_rs1 = 1'b1;
        dec_uses_rs2 = 1'b1;
        case (funct3)
          3'b000:  dec_ctrl = 9'h006;
          3'b001:  dec_ctrl = 9'h00A;
          3'b010:  dec_ctrl = 9'h00E;
          default: dec_ctrl = 9'h102;
        endcase
      end
      default: begin
        dec_ctrl = 9'h100;
      end
    endcase
    dec_rd = dec_ctrl[0] ? id_instr[11:7] : 5'd0;
  end

  // A load sitting in stage 0 whose result the ID instruction needs cannot
  // be forwarded in time, so ID must wait one cycle. A load targeting x0
  // produces nothing worth waiting for.
  always_comb begin
    hazard = LOAD_USE_EN && valid_q[0] && ctrl_q[0][5] && (rd_q[0] != 5'd0) &&
             id_valid &&
             ((dec_uses_rs1 && (rd_q[0] == id_instr[19:15])) ||
              (dec_uses_rs2 && (rd_q[0] == id_instr[24:20])));
  end

  // ID is accepted unless we are in reset, stalled, or bubbling for a
  // load-use hazard. A flush wins over the hazard because the ID instruction
  // is being thrown away anyway.
  assign id_ready = !rst && !stall_i && (flush_i || !hazard);

  // Control pipe registers. A stall freezes every stage, including the
  // counter, and hides any flush or hazard for that cycle. Otherwise the
  // upper stages always shift, and stage 0 receives a bubble on a flush or
  // hazard, or the freshly decoded instruction otherwise. Only a real
  // load-use bubble counts, and the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int s = 0; s < CTRL_DEPTH; s++) begin
        ctrl_q[s] <= 9'd0;
        rd_q[s]   <= 5'd0;
      end
      cnt_q <= '0;
    end else if (!stall_i) begin
      for (int s = 1; s < CTRL_DEPTH; s++) begin
        valid_q[s] <= valid_q[s-1];
        ctrl_q[s]  <= ctrl_q[s-1];
        rd_q[s]    <= rd_q[s-1];
      end
      if (flush_i || hazard) begin
        valid_q[0] <= 1'b0;
        ctrl_q[0]  <= 9'd0;
        rd_q[0]    <= 5'd0;
      end else begin
        valid_q[0] <= id_valid;
        ctrl_q[0]  <= dec_ctrl;
        rd_q[0]    <= dec_rd;
      end
      if (!flush_i && hazard && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Flatten the per-stage registers onto the packed output buses.
  for (genvar g = 0; g < CTRL_DEPTH; g++) begin : g_pack
    assign stage_valid[g]       = valid_q[g];
    assign stage_ctrl[9*g +: 9] = ctrl_q[g];
    assign stage_rd[5*g +: 5]   = rd_q[g];
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// ---------------------------------------------------------------------------
// tb_ctrl_pipe
// Self-checking bench for ctrl_pipe. Two instances share the same stimulus:
// one with the default 16-bit bubble counter and one with a 2-bit counter,
// so that saturation is reached quickly. A behavioural model tracks the
// pipeline as a small array of stage entries and counts bubbles as a plain
// integer. Directed sequences come first, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_ctrl_pipe;

  localparam int D = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [31:0]   id_instr;
  logic          stall_i;
  logic          flush_i;

  logic          id_ready;
  logic [D-1:0]  stage_valid;
  logic [D*9-1:0] stage_ctrl;
  logic [D*5-1:0] stage_rd;
  logic [15:0]   bubble_cnt;

  logic          sat_ready;
  logic [D-1:0]  sat_valid;
  logic [D*9-1:0] sat_ctrl;
  logic [D*5-1:0] sat_rd;
  logic [1:0]    sat_cnt;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    bit       valid;
    bit [8:0] ctrl;
    bit [4:0] rd;
    bit       is_load;
  } entry_t;

  entry_t m_stage [D];
  int     m_bubbles;

  ctrl_pipe #(.CTRL_DEPTH(D), .CNT_W(16), .LOAD_USE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_ready(id_ready), .stall_i(stall_i), .flush_i(flush_i),
    .stage_valid(stage_valid), .stage_ctrl(stage_ctrl), .stage_rd(stage_rd),
    .bubble_cnt(bubble_cnt)
  );

  ctrl_pipe #(.CTRL_DEPTH(D), .CNT_W(2), .LOAD_USE_EN(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_ready(sat_ready), .stall_i(stall_i), .flush_i(flush_i),
    .stage_valid(sat_valid), .stage_ctrl(sat_ctrl), .stage_rd(sat_rd),
    .bubble_cnt(sat_cnt)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference decode, built from the named control flags of each
  // instruction class and the register-read rules.
  task automatic modelDecode(input bit [31:0] instr, output bit [8:0] ctrl,
                             output bit [4:0] rd, output bit u1, output bit u2);
    bit illegal, jump, branch, memread, memtoreg, alusrc, regwrite;
    int memwrite;
    illegal = 0; jump = 0; branch = 0; memread = 0; memtoreg = 0;
    alusrc = 0; regwrite = 0; memwrite = 0; u1 = 0; u2 = 0;
    case (instr[6:0])
      7'h37, 7'h17: begin alusrc = 1; regwrite = 1; end
      7'h13:        begin alusrc = 1; regwrite = 1; u1 = 1; end
      7'h33:        begin regwrite = 1; u1 = 1; u2 = 1; end
      7'h6F:        begin jump = 1; alusrc = 1; regwrite = 1; end
      7'h67:        begin jump = 1; alusrc = 1; regwrite = 1; u1 = 1; end
      7'h63:        begin branch = 1; u1 = 1; u2 = 1; end
      7'h03:        begin memread = 1; memtoreg = 1; alusrc = 1; regwrite = 1; u1 = 1; end
      7'h23: begin
        alusrc = 1; u1 = 1; u2 = 1;
        if (instr[14:12] <= 3'd2) memwrite = int'(instr[14:12]) + 1;
        else illegal = 1;
      end
      default: illegal = 1;
    endcase
    ctrl = 9'(illegal * 256 + jump * 128 + branch * 64 + memread * 32 +
              memtoreg * 16 + memwrite * 4 + alusrc * 2 + regwrite);
    rd = regwrite ? instr[11:7] : 5'd0;
  endtask

  // Drive one cycle of inputs, check id_ready against the model, advance
  // the model across the clock edge and check every registered output.
  task automatic applyStimulus(input bit r, input bit v, input bit [31:0] instr,
                               input bit st, input bit fl);
    bit [8:0] c;
    bit [4:0] d;
    bit       u1, u2, hz, exp_ready;
    int       exp16, exp2;
    @(negedge clk);
    rst = r; id_valid = v; id_instr = instr; stall_i = st; flush_i = fl;
    #1;
    modelDecode(instr, c, d, u1, u2);
    hz = m_stage[0].valid && m_stage[0].is_load && (m_stage[0].rd != 0) && v &&
         ((u1 && m_stage[0].rd == instr[19:15]) || (u2 && m_stage[0].rd == instr[24:20]));
    exp_ready = !r && !st && (fl || !hz);
    checkOutput("id_ready", 32'(id_ready), 32'(exp_ready));
    if (r) begin
      for (int s = 0; s < D; s++) m_stage[s] = '{0, 0, 0, 0};
      m_bubbles = 0;
    end else if (!st) begin
      for (int s = D - 1; s > 0; s--) m_stage[s] = m_stage[s-1];
      if (fl || hz) m_stage[0] = '{0, 0, 0, 0};
      else          m_stage[0] = '{v, c, d, c[5]};
      if (!fl && hz) m_bubbles++;
    end
    @(posedge clk);
    #1;
    for (int s = 0; s < D; s++) begin
      checkOutput($sformatf("valid[%0d]", s), 32'(stage_valid[s]), 32'(m_stage[s].valid));
      if (m_stage[s].valid || r) begin
        checkOutput($sformatf("ctrl[%0d]", s), 32'(stage_ctrl[9*s +: 9]), 32'(m_stage[s].ctrl));
        checkOutput($sformatf("rd[%0d]", s), 32'(stage_rd[5*s +: 5]), 32'(m_stage[s].rd));
      end
    end
    exp16 = (m_bubbles > 65535) ? 65535 : m_bubbles;
    exp2  = (m_bubbles > 3) ? 3 : m_bubbles;
    checkOutput("bubble_cnt", 32'(bubble_cnt), 32'(exp16));
    checkOutput("bubble_cnt_sat", 32'(sat_cnt), 32'(exp2));
  endtask

  // Random instruction with small register numbers so hazards are common.
  function automatic bit [31:0] randInstr();
    bit [6:0] ops [10];
    bit [6:0] op;
    ops = '{7'h37, 7'h17, 7'h13, 7'h33, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};
    op = ops[$urandom_range(0, 9)];
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), op};
  endfunction

  localparam bit [31:0] ADD   = 32'h002081B3;
  localparam bit [31:0] LW2   = 32'h0000A103;
  localparam bit [31:0] LW0   = 32'h0000A003;
  localparam bit [31:0] BEQ   = 32'h00208063;
  localparam bit [31:0] NOP   = 32'h00000013;

  initial begin
    rst = 1'b1; id_valid = 1'b1; id_instr = ADD; stall_i = 1'b0; flush_i = 1'b0;
    for (int s = 0; s < D; s++) m_stage[s] = '{0, 0, 0, 0};
    m_bubbles = 0;

    $display("[TB] reset and first OP");
    applyStimulus(1, 1, ADD, 0, 0);
    applyStimulus(1, 1, ADD, 0, 0);
    applyStimulus(0, 1, ADD, 0, 0);
    checkOutput("op_ctrl_const", 32'(stage_ctrl[8:0]), 32'h001);
    checkOutput("op_rd_const", 32'(stage_rd[4:0]), 32'd3);

    $display("[TB] load-use bubble");
    applyStimulus(0, 1, LW2, 0, 0);
    applyStimulus(0, 1, ADD, 0, 0);
    checkOutput("bubble_valid0", 32'(stage_valid[0]), 32'd0);
    checkOutput("bubble_cnt_one", 32'(bubble_cnt), 32'd1);
    applyStimulus(0, 1, ADD, 0, 0);

    $display("[TB] load to x0, no bubble");
    applyStimulus(0, 1, LW0, 0, 0);
    applyStimulus(0, 1, ADD, 0, 0);
    checkOutput("x0_no_bubble", 32'(bubble_cnt), 32'd1);

    $display("[TB] flush behind a branch");
    applyStimulus(0, 1, BEQ, 0, 0);
    applyStimulus(0, 1, ADD, 0, 1);
    checkOutput("flush_s1_beq", 32'(stage_ctrl[17:9]), 32'h040);

    $display("[TB] stall over hazard and flush");
    applyStimulus(0, 1, LW2, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, ADD, 1, 1);
    checkOutput("stall_cnt", 32'(bubble_cnt), 32'd1);
    applyStimulus(0, 1, ADD, 0, 1);
    applyStimulus(0, 1, ADD, 0, 0);

    $display("[TB] store widths and illegal opcode");
    applyStimulus(0, 1, 32'h00208023, 0, 0);
    applyStimulus(0, 1, 32'h00209023, 0, 0);
    applyStimulus(0, 1, 32'h0020A023, 0, 0);
    applyStimulus(0, 1, 32'h0020B023, 0, 0);
    checkOutput("sw_illegal_f3", 32'(stage_ctrl[8:0]), 32'h102);
    applyStimulus(0, 1, 32'h00000F7F, 0, 0);
    checkOutput("illegal_ctrl", 32'(stage_ctrl[8:0]), 32'h100);
    checkOutput("illegal_rd", 32'(stage_rd[4:0]), 32'd0);

    $display("[TB] counter saturation");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, LW2, 0, 0);
      applyStimulus(0, 1, ADD, 0, 0);
      applyStimulus(0, 1, ADD, 0, 0);
    end
    checkOutput("sat_hold", 32'(sat_cnt), 32'd3);
    applyStimulus(0, 0, NOP, 0, 0);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                    randInstr(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
